// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared encodings and FSM state type for the SR latch driver
package sr_pkg;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SET     = 2'b01;
  localparam logic [1:0] OP_RESET   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_sync2.sv
// rtl/sr_sync2.sv - two-flop synchronizer for one asynchronous readback bit
module sr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_driver.sv
// rtl/sr_driver.sv - pulses s/r into an external SR latch and confirms the result by readback
module sr_driver
  import sr_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       s,
  output logic       r,
  input  logic       q,
  input  logic       qn,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       state_q
);

  localparam int CNT_MAX = max_int(PULSE_W, TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DRIVE_LAST  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          expected;
  logic          q_s;
  logic          qn_s;
  logic          accept;
  logic          match;

  sr_sync2 u_sync_q (
    .clk (clk),
    .rst (rst),
    .d   (q),
    .q   (q_s)
  );

  sr_sync2 u_sync_qn (
    .clk (clk),
    .rst (rst),
    .d   (qn),
    .q   (qn_s)
  );

  // Held low during reset so nothing is accepted on the edge that clears the FSM.
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign match     = (q_s == expected) && (qn_s == ~expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      state_q  <= 1'b0;
      cnt      <= '0;
      expected <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            cnt      <= '0;
            case (cmd_op)
              OP_SET: begin
                s        <= 1'b1;
                expected <= 1'b1;
                state    <= ST_DRIVE;
              end
              OP_RESET: begin
                r        <= 1'b1;
                expected <= 1'b0;
                state    <= ST_DRIVE;
              end
              OP_NOP: begin
                done  <= 1'b1;
                state <= ST_DONE;
              end
              default: begin
                done     <= 1'b1;
                err      <= 1'b1;
                err_code <= ERR_ILLEGAL;
                state    <= ST_DONE;
              end
            endcase
          end
        end

        ST_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            s     <= 1'b0;
            r     <= 1'b0;
            cnt   <= '0;
            state <= ST_SETTLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // A match wins even on the final allowed cycle.
        ST_SETTLE: begin
          if (match) begin
            state_q <= expected;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if (cnt == SETTLE_LAST) begin
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= (q_s == qn_s) ? ERR_INVALID : ERR_TIMEOUT;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          s     <= 1'b0;
          r     <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_driver.sv
// tb/tb_sr_driver.sv - directed scoreboard bench for sr_driver with a behavioural SR latch
module tb_sr_driver;

  localparam int PW = 4;
  localparam int TO = 15;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       s;
  logic       r;
  logic       q;
  logic       qn;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       state_q;

  logic model_on;
  logic lq;
  logic stuck_q;
  logic stuck_qn;
  int   overlap;
  int   compared;
  int   mismatched;

  typedef struct {
    int         lat;
    int         s_cycles;
    int         r_cycles;
    logic       err;
    logic [1:0] code;
    logic       sq;
  } exp_t;

  exp_t sb[$];

  sr_driver #(.PULSE_W(PW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .s         (s),
    .r         (r),
    .q         (q),
    .qn        (qn),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .state_q   (state_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign q  = model_on ? lq  : stuck_q;
  assign qn = model_on ? ~lq : stuck_qn;

  // Latch responds half a cycle after the drive it sees; also watches for s/r overlap.
  always @(negedge clk) begin
    if (s && r) overlap++;
    if (s) lq = 1'b1;
    else if (r) lq = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic collect(output int lat, output int sc, output int rc, output bit got);
    lat = 0;
    sc  = 0;
    rc  = 0;
    got = 0;
    while (!got && lat < 200) begin
      if (done === 1'b1) got = 1;
      else begin
        if (s) sc++;
        if (r) rc++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic score(input bit got, input int lat, input int sc, input int rc);
    exp_t x;
    chk("done_seen", 32'(got), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("latency", lat, x.lat);
      chk("s_cycles", sc, x.s_cycles);
      chk("r_cycles", rc, x.r_cycles);
      chk("err", 32'(err), 32'(x.err));
      chk("err_code", 32'(err_code), 32'(x.code));
      chk("state_q", 32'(state_q), 32'(x.sq));
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int lat, input int sc, input int rc,
                         input logic e, input logic [1:0] code, input logic sq);
    int ol;
    int os;
    int orr;
    bit got;
    sb.push_back('{lat, sc, rc, e, code, sq});
    chk("ready_before", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    if (op != 2'b11) chk("err_cleared_on_accept", 32'(err), 32'd0);
    collect(ol, os, orr, got);
    score(got, ol, os, orr);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int ol;
    int os;
    int orr;
    int seen;
    bit got;
    compared   = 0;
    mismatched = 0;
    overlap    = 0;
    model_on   = 1'b1;
    lq         = 1'b0;
    stuck_q    = 1'b0;
    stuck_qn   = 1'b1;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;

    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_state_q", 32'(state_q), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    run_cmd(2'b01, PW + 1, PW, 0, 1'b0, 2'b00, 1'b1);
    run_cmd(2'b10, PW + 1, 0, PW, 1'b0, 2'b00, 1'b0);
    run_cmd(2'b11, 0, 0, 0, 1'b1, 2'b01, 1'b0);
    run_cmd(2'b00, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    model_on = 1'b0;
    stuck_q  = 1'b0;
    stuck_qn = 1'b1;
    run_cmd(2'b01, PW + TO, PW, 0, 1'b1, 2'b10, 1'b0);
    stuck_q  = 1'b1;
    stuck_qn = 1'b1;
    run_cmd(2'b01, PW + TO, PW, 0, 1'b1, 2'b11, 1'b0);
    repeat (2) @(negedge clk);
    chk("err_holds_idle", 32'(err), 32'd1);
    chk("err_code_holds_idle", 32'(err_code), 32'd3);

    model_on  = 1'b1;
    cmd_op    = 2'b01;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_drive_s", 32'(s), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_s_low", 32'(s), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_released", 32'(cmd_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("abort_no_late_done", seen, 0);

    sb.push_back('{PW + 1, PW, 0, 1'b0, 2'b00, 1'b1});
    sb.push_back('{PW + 1, 0, PW, 1'b0, 2'b00, 1'b0});
    cmd_op    = 2'b01;
    cmd_valid = 1'b1;
    @(negedge clk);
    collect(ol, os, orr, got);
    score(got, ol, os, orr);
    chk("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
    cmd_op = 2'b10;
    @(negedge clk);
    chk("b2b_ready_idle", 32'(cmd_ready), 32'd1);
    chk("b2b_r_not_yet", 32'(r), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_r_started", 32'(r), 32'd1);
    collect(ol, os, orr, got);
    score(got, ol, os, orr);
    @(negedge clk);
    chk("b2b_done_one_cycle", 32'(done), 32'd0);

    chk("s_r_overlap", overlap, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
